// File: rtl/bean_scheduler.sv
// rtl/bean_scheduler.sv - per-frame bean slot controller: scroll, retire, collide, spawn
// Optional feature macro: BEAN_SPEEDUP_EN (scroll speed grows with score, capped at 8 px/frame)
module bean_scheduler #(
  parameter int N_BEANS    = 4,
  parameter int BEAN_W     = 30,
  parameter int BEAN_H     = 40,
  parameter int BEAN_Y_BOT = 380,
  parameter int GOOSE_W    = 32,
  parameter int GOOSE_H    = 32,
  parameter int SPEED      = 2,
  parameter int SPAWN_X    = 640,
  parameter int MIN_GAP    = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   run,
  input  logic [9:0]             goose_x,
  input  logic [9:0]             goose_y,
  output logic [10*N_BEANS-1:0]  bean_x,
  output logic [N_BEANS-1:0]     bean_active,
  output logic                   busy,
  output logic                   hit,
  output logic [7:0]             score
);

  localparam int IDX_W = $clog2(N_BEANS);

  typedef enum logic [1:0] {IDLE, SCAN, SPAWN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       spawn_cnt;
  logic [7:0]       lfsr;
  logic [9:0]       xs [N_BEANS];
  logic [9:0]       speed;
  logic [9:0]       cur_x;
  logic [10:0]      nx;
  logic             retire;
  logic             collide;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [7:0]       lfsr_next;

  for (genvar g = 0; g < N_BEANS; g++) begin : g_pack
    assign bean_x[10*g +: 10] = xs[g];
  end

`ifdef BEAN_SPEEDUP_EN
  // Speed is latched at the tick so a score change only affects the following frame.
  logic [3:0] frame_speed;
  logic [5:0] speed_sum;
  assign speed_sum = 6'(SPEED) + {1'b0, score[7:3]};
  assign speed     = {6'b0, frame_speed};
`else
  assign speed = 10'(SPEED);
`endif

  assign cur_x     = xs[idx];
  assign retire    = (cur_x <= speed);
  assign nx        = {1'b0, cur_x} - {1'b0, speed};
  assign collide   = (nx <= {1'b0, goose_x} + 11'(GOOSE_W))
                  && ({1'b0, goose_x} <= nx + 11'(BEAN_W))
                  && (11'(BEAN_Y_BOT - BEAN_H) <= {1'b0, goose_y} + 11'(GOOSE_H))
                  && ({1'b0, goose_y} <= 11'(BEAN_Y_BOT));
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_BEANS - 1; i >= 0; i--) begin
      if (!bean_active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      hit         <= 1'b0;
      score       <= 8'd0;
      spawn_cnt   <= 8'(MIN_GAP);
      lfsr        <= 8'hA5;
      bean_active <= '0;
      for (int i = 0; i < N_BEANS; i++) xs[i] <= 10'd0;
`ifdef BEAN_SPEEDUP_EN
      frame_speed <= 4'(SPEED);
`endif
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick && run) begin
            state <= SCAN;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef BEAN_SPEEDUP_EN
            frame_speed <= (speed_sum > 6'd8) ? 4'd8 : speed_sum[3:0];
`endif
          end
        end
        SCAN: begin
          if (bean_active[idx]) begin
            if (retire) begin
              bean_active[idx] <= 1'b0;
            end else begin
              xs[idx] <= nx[9:0];
              if (collide) begin
                bean_active[idx] <= 1'b0;
                hit              <= 1'b1;
                if (score != 8'hFF) score <= score + 8'd1;
              end
            end
          end
          if (idx == IDX_W'(N_BEANS - 1)) state <= SPAWN;
          else                            idx   <= idx + 1'b1;
        end
        SPAWN: begin
          lfsr <= lfsr_next;
          // With no free slot the counter stays at zero so the spawn retries next frame.
          if (spawn_cnt != 8'd0) begin
            spawn_cnt <= spawn_cnt - 8'd1;
          end else if (free_found) begin
            bean_active[free_idx] <= 1'b1;
            xs[free_idx]          <= 10'(SPAWN_X);
            spawn_cnt             <= 8'(MIN_GAP) + {3'b0, lfsr[4:0]};
          end
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bean_scheduler.sv
// tb/tb_bean_scheduler.sv - bench for bean_scheduler: vector table, frame-level model, saturation run
module tb_bean_scheduler;
  localparam int N       = 4;
  localparam int BEAN_W  = 30;
  localparam int BEAN_H  = 40;
  localparam int Y_BOT   = 380;
  localparam int GOOSE_W = 32;
  localparam int GOOSE_H = 32;
  localparam int SPEED   = 2;
  localparam int SPAWN_X = 640;
  localparam int MIN_GAP = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, frame_tick, run;
  logic [9:0]        goose_x, goose_y;
  logic [10*N-1:0]   bean_x;
  logic [N-1:0]      bean_active;
  logic              busy, hit;
  logic [7:0]        score;

  logic              s_reset, s_tick, s_run;
  logic [9:0]        s_gx, s_gy;
  logic [10*N-1:0]   s_bean_x;
  logic [N-1:0]      s_active;
  logic              s_busy, s_hit;
  logic [7:0]        s_score;

  bean_scheduler #(.N_BEANS(N)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run),
    .goose_x(goose_x), .goose_y(goose_y), .bean_x(bean_x),
    .bean_active(bean_active), .busy(busy), .hit(hit), .score(score)
  );

  bean_scheduler #(.N_BEANS(N), .MIN_GAP(0)) dut_sat (
    .clk(clk), .reset(s_reset), .frame_tick(s_tick), .run(s_run),
    .goose_x(s_gx), .goose_y(s_gy), .bean_x(s_bean_x),
    .bean_active(s_active), .busy(s_busy), .hit(s_hit), .score(s_score)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: whole-frame effect of one accepted tick.
  int         m_x [N];
  bit         m_act [N];
  int         m_score, m_cnt, m_hits;
  logic [7:0] m_lfsr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_act[i] = 0; end
    m_score = 0; m_cnt = MIN_GAP; m_lfsr = 8'hA5; m_hits = 0;
  endfunction

  function automatic void model_frame(input int gx, input int gy);
    int spd;
    int slot;
    spd = SPEED;
`ifdef BEAN_SPEEDUP_EN
    spd = SPEED + m_score / 8;
    if (spd > 8) spd = 8;
`endif
    m_hits = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_x[i] <= spd) m_act[i] = 0;
        else begin
          m_x[i] = m_x[i] - spd;
          if (m_x[i] <= gx + GOOSE_W && gx <= m_x[i] + BEAN_W &&
              Y_BOT - BEAN_H <= gy + GOOSE_H && gy <= Y_BOT) begin
            m_act[i] = 0;
            m_hits++;
            if (m_score < 255) m_score++;
          end
        end
      end
    end
    if (m_cnt != 0) m_cnt--;
    else begin
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      if (slot >= 0) begin
        m_act[slot] = 1; m_x[slot] = SPAWN_X;
        m_cnt = MIN_GAP + int'(m_lfsr & 8'h1F);
      end
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endfunction

  function automatic logic [63:0] m_mask();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [63:0] m_xs();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One tick; extra_at/drop_at place a second tick or a run drop that many samples later.
  task automatic do_frame(input bit r, input int gx, input int gy,
                          input int extra_at, input int drop_at, output int hits_seen);
    int busy_n;
    @(negedge clk);
    run = r; goose_x = 10'(gx); goose_y = 10'(gy); frame_tick = 1'b1;
    busy_n = 0; hits_seen = 0;
    for (int c = 0; c < N + 6; c++) begin
      @(negedge clk);
      frame_tick = (c == extra_at);
      if (c == drop_at) run = 1'b0;
      busy_n    += int'(busy);
      hits_seen += int'(hit);
    end
    frame_tick = 1'b0;
    if (r) model_frame(gx, gy);
    check("busy_cycles", 64'(busy_n), r ? 64'(N + 2) : 64'd0);
    check("frame_hits", 64'(hits_seen), r ? 64'(m_hits) : 64'd0);
    check("active_mask", 64'(bean_active), m_mask());
    check("bean_x", 64'(bean_x), m_xs());
    check("score", 64'(score), 64'(m_score));
  endtask

  typedef struct {
    bit rst; bit run; int gx; int gy; int ticks;
    bit chk0; int x0; bit act0; int score; int hits;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h, hsum, s_hits, frames;
    bit seen255;
    reset = 1'b1; frame_tick = 1'b0; run = 1'b0; goose_x = '0; goose_y = '0;
    s_reset = 1'b1; s_tick = 1'b0; s_run = 1'b0; s_gx = '0; s_gy = '0;

    tbl[0] = '{1, 1,   0,   0,  40, 1,   0, 0, 0, 0};
    tbl[1] = '{0, 1,   0,   0,   1, 1, 640, 1, 0, 0};
    tbl[2] = '{0, 1,   0,   0,  10, 1, 620, 1, 0, 0};
    tbl[3] = '{0, 0,   0,   0,   5, 1, 620, 1, 0, 0};
    tbl[4] = '{0, 1,   0,   0, 309, 1,   2, 1, 0, 0};
    tbl[5] = '{0, 1,   0,   0,   1, 0,   0, 0, 0, 0};
    tbl[6] = '{1, 1,   0,   0,  41, 1, 640, 1, 0, 0};
    tbl[7] = '{0, 1, 300, 350, 153, 1, 334, 1, 0, 0};
    tbl[8] = '{0, 1, 300, 350,   1, 0,   0, 0, 1, 1};

    do_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_active", 64'(bean_active), 64'd0);
    check("rst_bean_x", 64'(bean_x), 64'd0);

    // Reset in the middle of an update must abort it.
    @(negedge clk); run = 1'b1; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (N + 4) @(negedge clk);
    check("midrst_still_idle", 64'(busy), 64'd0);
    check("midrst_active", 64'(bean_active), 64'd0);
    model_reset();

    for (int r = 0; r < 9; r++) begin
      if (tbl[r].rst) do_reset();
      hsum = 0;
      for (int t = 0; t < tbl[r].ticks; t++) begin
        do_frame(tbl[r].run, tbl[r].gx, tbl[r].gy, -1, -1, h);
        hsum += h;
      end
      if (tbl[r].chk0) begin
        check($sformatf("tbl%0d_x0", r), 64'(bean_x[9:0]), 64'(tbl[r].x0));
        check($sformatf("tbl%0d_act0", r), 64'(bean_active[0]), 64'(tbl[r].act0));
      end
      check($sformatf("tbl%0d_score", r), 64'(score), 64'(tbl[r].score));
      check($sformatf("tbl%0d_hits", r), 64'(hsum), 64'(tbl[r].hits));
    end

    // Second tick two cycles after the first is dropped, not queued.
    do_frame(1, 0, 0, 1, -1, h);
    do_frame(0, 0, 0, -1, -1, h);
    do_frame(1, 0, 0, -1, 1, h);
    do_frame(0, 0, 0, -1, -1, h);

    for (int k = 0; k < 800; k++) begin
      bit r;
      int gx, gy, ex, dr, sel;
      r   = ($urandom_range(0, 9) != 0);
      gx  = $urandom_range(0, 700);
      sel = $urandom_range(0, 2);
      gy  = (sel == 0) ? 0 : (sel == 1) ? 350 : $urandom_range(0, 1023);
      ex  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N) : -1;
      dr  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N) : -1;
      do_frame(r, gx, gy, ex, dr, h);
    end

    // Saturation: goose parked at the spawn point catches every new bean.
    @(negedge clk); s_reset = 1'b0; s_run = 1'b1; s_gx = 10'd610; s_gy = 10'd350;
    s_hits = 0; frames = 0; seen255 = 1'b0;
    while (s_hits < 256 && frames < 12000) begin
      @(negedge clk); s_tick = 1'b1;
      for (int c = 0; c < N + 4; c++) begin
        @(negedge clk);
        s_tick = 1'b0;
        s_hits += int'(s_hit);
      end
      frames++;
      if (s_hits >= 255 && !seen255) begin
        seen255 = 1'b1;
        check("sat_score_at_255", 64'(s_score), 64'd255);
      end else if (frames % 64 == 0) begin
        check("sat_score_track", 64'(s_score), 64'(s_hits > 255 ? 255 : s_hits));
      end
    end
    check("sat_total_hits", 64'(s_hits), 64'd256);
    check("sat_score_final", 64'(s_score), 64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bean_scheduler.md
Name: bean_scheduler

Overview:
- Per-frame controller for the bean obstacles drawn by the bean renderer.
- Owns N bean slots and, once per frame tick, scrolls each active bean left, retires off-screen beans, detects goose/bean overlap and spawns new beans after a pseudo-random gap.
- Outputs packed bean x positions and an active mask to the pixel-draw logic, plus hit/score to game control.
- Updates occur only after frame_tick (start of vblank), so draw inputs are stable during active video.

Parameters:
- N_BEANS, 4, number of bean slots (2..8).
- BEAN_W, 30, bean width in pixels.
- BEAN_H, 40, bean height in pixels.
- BEAN_Y_BOT, 380, bean bottom row; bean spans rows BEAN_Y_BOT-BEAN_H..BEAN_Y_BOT.
- GOOSE_W, 32, goose hitbox width.
- GOOSE_H, 32, goose hitbox height.
- SPEED, 2, pixels moved left per frame.
- SPAWN_X, 640, x assigned to a newly spawned bean.
- MIN_GAP, 40, minimum frames between spawns.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse at vblank start
- run  in  1  game running; 0 freezes all bean state
- goose_x  in  10  goose hitbox left column
- goose_y  in  10  goose hitbox top row
- bean_x  out  10*N_BEANS  slot i x in bits [10i+9:10i]
- bean_active  out  N_BEANS  slot valid mask
- busy  out  1  high while a frame update is in progress
- hit  out  1  one-cycle pulse per collected bean
- score  out  8  beans collected, saturating at 255

Behaviour:
- Reset: bean_active=0, all bean_x=0, busy=0, hit=0, score=0, spawn_cnt=MIN_GAP, lfsr=8'hA5, state=IDLE. Reset mid-update aborts the update immediately.
- States: IDLE, SCAN, SPAWN, DONE.
- IDLE:
  - frame_tick & run -> SCAN, idx=0, busy=1.
  - Otherwise stay in IDLE.
  - frame_tick while busy, or while run=0, is ignored with no queuing.
- SCAN: one slot per cycle, idx 0..N_BEANS-1.
  - If the slot is active and x <= SPEED: clear active (bean left the screen).
  - Else if the slot is active: x <= x - SPEED, then evaluate collision using the new x.
  - Collision test, inclusive, 11-bit unsigned arithmetic: nx <= goose_x+GOOSE_W && goose_x <= nx+BEAN_W && BEAN_Y_BOT-BEAN_H <= goose_y+GOOSE_H && goose_y <= BEAN_Y_BOT.
  - On collision: clear active, pulse hit for that cycle, score+1 (saturating).
  - Multiple collisions in one frame give multiple separate hit pulses.
  - Inactive slots are untouched.
  - After the last slot -> SPAWN.
- SPAWN:
  - If spawn_cnt != 0: spawn_cnt - 1.
  - If spawn_cnt == 0 and a free slot exists: the lowest-index free slot becomes active with x=SPAWN_X; spawn_cnt <= MIN_GAP + lfsr[4:0].
  - If spawn_cnt == 0 and no slot is free: spawn_cnt holds at 0 and the spawn retries next frame.
  - Go to DONE.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances once per SPAWN cycle.
- DONE: busy <= 0, go to IDLE.
- Latency:
  - busy rises the cycle after the tick.
  - The update completes in N_BEANS+2 cycles after the tick; busy=0 again at tick+N_BEANS+3.
- run dropping mid-update: the current update completes; the next tick is ignored.
- Collision is evaluated only during SCAN using the goose_x/goose_y sampled in that cycle.

Optional Feature:
- Macro: BEAN_SPEEDUP_EN.
- With the macro defined:
  - Effective speed = SPEED + score[7:3], capped at 8 pixels/frame.
  - Retire condition uses the effective speed.
  - Speed changes take effect on the frame after the score increment.
- Without the macro: constant SPEED, and no extra logic is present.

Test Plan:
- Reset, run=1, 40 ticks, goose_x=0, goose_y=0 -> no spawn on ticks 1-40 (spawn_cnt 40..1 counts down); tick 41 -> slot0 active, bean_x[9:0]=640; busy high for exactly N_BEANS+2 cycles per tick.
- Slot0 at 640, goose far away, 10 ticks -> bean_x[9:0]=620; at x=2, next tick -> bean_active[0]=0, hit stays 0.
- Goose_x=300, goose_y=350, slot0 moving from 334 -> on the tick producing x=332 (332 <= 332): hit pulses one cycle, score=1, slot0 cleared.
- All 4 slots active, spawn_cnt=0 -> no spawn and spawn_cnt stays 0; free slot2 by retirement -> the next tick spawns into slot2 at 640.
- Second frame_tick asserted 2 cycles after the first, and tick with run=0 -> both ignored; beans, score and spawn_cnt unchanged.
- Score preloaded to 255 by 255 collisions, one more collision -> hit pulses, score stays 255. With BEAN_SPEEDUP_EN and score=16 -> bean moves 4 px/frame.
